// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus: address map, TCON bit layout,
// the value driven for unmapped reads, and the address decoder.
package periph_bus_pkg;

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  localparam int TCON_EN    = 0;
  localparam int TCON_IRQEN = 1;
  localparam int TCON_IRQ   = 2;

  localparam logic [31:0] UNMAPPED_RD = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_SWITCH,
    SEL_SYSTICK
  } sel_e;

  // Word-aligned decode: the two byte-offset bits never take part.
  // The RAM occupies the bottom 4*2^ram_aw bytes of the map.
  function automatic sel_e decode_addr(input logic [31:0] addr, input int ram_aw);
    sel_e sel;
    sel = SEL_NONE;
    if ((addr >> (ram_aw + 2)) == 32'd0) begin
      sel = SEL_RAM;
    end else begin
      case (addr[31:2])
        ADDR_TH[31:2]:      sel = SEL_TH;
        ADDR_TL[31:2]:      sel = SEL_TL;
        ADDR_TCON[31:2]:    sel = SEL_TCON;
        ADDR_LED[31:2]:     sel = SEL_LED;
        ADDR_SWITCH[31:2]:  sel = SEL_SWITCH;
        ADDR_SYSTICK[31:2]: sel = SEL_SYSTICK;
        default:            sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/periph_bus_data_ram.sv
// Data RAM: combinational read so the CPU sees data in the same cycle,
// write on the rising edge. Contents are deliberately not reset.
module data_ram #(
  parameter int RAM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_addr,
  input  logic [31:0]                  i_wdata,
  output logic [31:0]                  o_rdata
);

  logic [31:0] r_mem [RAM_DEPTH];

  // Synchronous word write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/periph_bus.sv
// Memory-mapped peripheral bus: data RAM, reloading timer with interrupt,
// LED register, synchronised switches and a free-running SYSTICK counter.
module periph_bus
  import periph_bus_pkg::*;
#(
  parameter int RAM_DEPTH = 256,
  parameter int IO_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Mem_Addr,
  input  logic                MemWr,
  input  logic [31:0]         MemWr_data,
  input  logic                MemRd,
  output logic [31:0]         MemRd_data,
  input  logic [IO_WIDTH-1:0] switch,
  output logic [IO_WIDTH-1:0] led,
  output logic                interrupt
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  sel_e                w_sel;
  logic                w_wr;
  logic                w_wr_th;
  logic                w_wr_tl;
  logic                w_wr_tcon;
  logic                w_wr_led;
  logic                w_ram_we;
  logic [31:0]         w_ram_rdata;
  logic                w_tick;
  logic                w_tl_max;
  logic                w_irq_set;
  logic [31:0]         w_tl_next;
  logic [2:0]          w_tcon_next;

  logic                r_live;
  logic [31:0]         r_th;
  logic [31:0]         r_tl;
  logic [2:0]          r_tcon;
  logic [IO_WIDTH-1:0] r_led;
  logic [IO_WIDTH-1:0] r_sw_meta;
  logic [IO_WIDTH-1:0] r_sw_sync;
  logic [31:0]         r_systick;
  logic                r_interrupt;

  assign w_sel = decode_addr(Mem_Addr, RAM_AW);

  // r_live stays low for the first edge after reset release, so that edge
  // neither writes nor counts.
  assign w_wr      = MemWr & r_live;
  assign w_wr_th   = w_wr && (w_sel == SEL_TH);
  assign w_wr_tl   = w_wr && (w_sel == SEL_TL);
  assign w_wr_tcon = w_wr && (w_sel == SEL_TCON);
  assign w_wr_led  = w_wr && (w_sel == SEL_LED);
  assign w_ram_we  = w_wr && (w_sel == SEL_RAM);

  assign w_tick    = r_live & r_tcon[TCON_EN];
  assign w_tl_max  = (r_tl == 32'hFFFF_FFFF);
  assign w_irq_set = w_tick & w_tl_max & r_tcon[TCON_IRQEN];

  data_ram #(
    .RAM_DEPTH(RAM_DEPTH)
  ) u_data_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_addr (Mem_Addr[RAM_AW+1:2]),
    .i_wdata(MemWr_data),
    .o_rdata(w_ram_rdata)
  );

  // Timer next state: a CPU write to TL beats the count, and an overflow
  // interrupt is OR-ed in after a TCON write so it is never lost.
  always_comb begin
    w_tl_next   = r_tl;
    w_tcon_next = r_tcon;
    if (w_wr_tl) begin
      w_tl_next = MemWr_data;
    end else if (w_tick) begin
      w_tl_next = w_tl_max ? r_th : (r_tl + 32'd1);
    end
    if (w_wr_tcon) begin
      w_tcon_next = MemWr_data[2:0];
    end
    if (w_irq_set) begin
      w_tcon_next[TCON_IRQ] = 1'b1;
    end
  end

  // Timer, interrupt and settle-flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live      <= 1'b0;
      r_th        <= '0;
      r_tl        <= '0;
      r_tcon      <= '0;
      r_interrupt <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      if (w_wr_th) begin
        r_th <= MemWr_data;
      end
      r_tl        <= w_tl_next;
      r_tcon      <= w_tcon_next;
      r_interrupt <= r_tcon[TCON_IRQEN] & r_tcon[TCON_IRQ];
    end
  end

  // LED register, switch two-flop synchroniser and SYSTICK counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led     <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_systick <= '0;
    end else begin
      if (w_wr_led) begin
        r_led <= MemWr_data[IO_WIDTH-1:0];
      end
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
      if (r_live) begin
        r_systick <= r_systick + 32'd1;
      end
    end
  end

  // Zero-latency read mux; idle or unmapped reads return UNMAPPED_RD.
  always_comb begin
    MemRd_data = UNMAPPED_RD;
    if (MemRd) begin
      case (w_sel)
        SEL_RAM:     MemRd_data = w_ram_rdata;
        SEL_TH:      MemRd_data = r_th;
        SEL_TL:      MemRd_data = r_tl;
        SEL_TCON:    MemRd_data = {29'd0, r_tcon};
        SEL_LED:     MemRd_data = 32'(r_led);
        SEL_SWITCH:  MemRd_data = 32'(r_sw_sync);
        SEL_SYSTICK: MemRd_data = r_systick;
        default:     MemRd_data = UNMAPPED_RD;
      endcase
    end
  end

  assign led       = r_led;
  assign interrupt = r_interrupt;

endmodule
